// File: rtl/flag_selector_pkg.sv
// Shared types, widths and defaults for the flag selector and its button debouncers.
package flag_selector_pkg;

    localparam int unsigned SEL_W  = 8;
    localparam int unsigned AUTO_W = 16;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_AUTO_FRAMES     = 300;

    typedef enum logic [1:0] {
        DB_UP        = 2'd0,
        DB_DOWN_WAIT = 2'd1,
        DB_DOWN      = 2'd2,
        DB_UP_WAIT   = 2'd3
    } db_state_e;

    // What the selector does on a frame_start cycle, in priority order.
    typedef enum logic [2:0] {
        ACT_HOLD   = 3'd0,
        ACT_EMPTY  = 3'd1,
        ACT_CLAMP  = 3'd2,
        ACT_CANCEL = 3'd3,
        ACT_NEXT   = 3'd4,
        ACT_PREV   = 3'd5,
        ACT_AUTO   = 3'd6
    } frame_act_e;

    // Forward step, wrapping at count-1; caller guarantees count != 0.
    function automatic logic [SEL_W-1:0] sel_step_next(input logic [SEL_W-1:0] sel,
                                                       input logic [SEL_W-1:0] cnt);
        return (sel == cnt - SEL_W'(1)) ? '0 : sel + SEL_W'(1);
    endfunction

    // Backward step, wrapping from 0 to count-1; caller guarantees count != 0.
    function automatic logic [SEL_W-1:0] sel_step_prev(input logic [SEL_W-1:0] sel,
                                                       input logic [SEL_W-1:0] cnt);
        return (sel == '0) ? cnt - SEL_W'(1) : sel - SEL_W'(1);
    endfunction

endpackage

// File: rtl/flag_selector_button_debounce.sv
// Two-flop synchronizer plus stable-level debouncer; emits one press pulse per accepted press.
module button_debounce
    import flag_selector_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_s;
    db_state_e        state;
    logic [CNT_W-1:0] cnt;

    assign btn_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    // Press is registered and only raised on the DOWN_WAIT -> DOWN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DB_UP;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                DB_UP: begin
                    cnt <= '0;
                    if (btn_s) begin
                        state <= DB_DOWN_WAIT;
                    end
                end
                DB_DOWN_WAIT: begin
                    if (!btn_s) begin
                        state <= DB_UP;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DB_DOWN;
                        cnt   <= '0;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DB_DOWN: begin
                    cnt <= '0;
                    if (!btn_s) begin
                        state <= DB_UP_WAIT;
                    end
                end
                DB_UP_WAIT: begin
                    if (btn_s) begin
                        state <= DB_DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DB_UP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= DB_UP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/flag_selector.sv
// Flag index generator: debounced next/prev buttons and auto-cycling, applied only at frame_start.
module flag_selector
    import flag_selector_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned AUTO_FRAMES     = DEF_AUTO_FRAMES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             auto_en,
    input  logic [SEL_W-1:0] count,
    output logic [SEL_W-1:0] selector,
    output logic             changed
);

    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);

    logic              press_next;
    logic              press_prev;
    logic              pend_next;
    logic              pend_prev;
    logic [AUTO_W-1:0] auto_cnt;

    logic              req_next_c;
    logic              req_prev_c;
    logic              auto_hit_c;
    frame_act_e        act_c;
    logic [SEL_W-1:0]  selector_d;
    logic              changed_d;
    logic              pend_next_d;
    logic              pend_prev_d;
    logic [AUTO_W-1:0] auto_cnt_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_next),
        .press (press_next)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_prev),
        .press (press_prev)
    );

    // A press landing on the frame_start cycle is honoured at that frame.
    assign req_next_c = pend_next | press_next;
    assign req_prev_c = pend_prev | press_prev;
    assign auto_hit_c = auto_en && (auto_cnt == AUTO_LAST);

    always_comb begin
        act_c = ACT_HOLD;
        if (count == '0) begin
            act_c = ACT_EMPTY;
        end else if (selector >= count) begin
            act_c = ACT_CLAMP;
        end else if (req_next_c && req_prev_c) begin
            act_c = ACT_CANCEL;
        end else if (req_next_c) begin
            act_c = ACT_NEXT;
        end else if (req_prev_c) begin
            act_c = ACT_PREV;
        end else if (auto_hit_c) begin
            act_c = ACT_AUTO;
        end
    end

    always_comb begin
        selector_d  = selector;
        changed_d   = 1'b0;
        pend_next_d = req_next_c;
        pend_prev_d = req_prev_c;
        auto_cnt_d  = auto_cnt;

        if (frame_start) begin
            pend_next_d = 1'b0;
            pend_prev_d = 1'b0;
            // A pre-empted auto advance still restarts its frame count.
            auto_cnt_d  = auto_hit_c ? '0 : auto_cnt + AUTO_W'(1);

            case (act_c)
                ACT_EMPTY: begin
                    selector_d = '0;
                end
                ACT_CLAMP: begin
                    selector_d = '0;
                    changed_d  = 1'b1;
                end
                ACT_NEXT, ACT_AUTO: begin
                    selector_d = sel_step_next(selector, count);
                    changed_d  = 1'b1;
                    auto_cnt_d = '0;
                end
                ACT_PREV: begin
                    selector_d = sel_step_prev(selector, count);
                    changed_d  = 1'b1;
                    auto_cnt_d = '0;
                end
                default: begin
                    selector_d = selector;
                end
            endcase
        end

        if (!auto_en) begin
            auto_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selector  <= '0;
            changed   <= 1'b0;
            pend_next <= 1'b0;
            pend_prev <= 1'b0;
            auto_cnt  <= '0;
        end else begin
            selector  <= selector_d;
            changed   <= changed_d;
            pend_next <= pend_next_d;
            pend_prev <= pend_prev_d;
            auto_cnt  <= auto_cnt_d;
        end
    end

endmodule

// File: tb/tb_flag_selector.sv
// Scoreboard bench for flag_selector: stimulus queues expected selector values, a monitor checks each changed pulse.
module tb_flag_selector;

    localparam int unsigned DB = 4;
    localparam int unsigned AF = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic [7:0] count;
    logic [7:0] selector;
    logic       changed;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [7:0] m_sel;

    flag_selector #(.DEBOUNCE_CYCLES(DB), .AUTO_FRAMES(AF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .auto_en     (auto_en),
        .count       (count),
        .selector    (selector),
        .changed     (changed)
    );

    always #5 clk = ~clk;

    // Monitor: every changed pulse must match the next queued selector value.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && changed === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_changed: selector=%0d with no change expected (t=%0t)", selector, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (selector !== mon_exp) begin
                    errors = errors + 1;
                    $display("FAIL changed_value: selector=%0d expected %0d (t=%0t)", selector, mon_exp, $time);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic press_btn(input bit nxt);
        if (nxt) btn_next = 1'b1; else btn_prev = 1'b1;
        repeat (10) tick();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (10) tick();
    endtask

    // One frame_start pulse; optionally queue the expected new selector, then check the settled value.
    task automatic frame(input bit expect_change, input logic [7:0] exp_sel);
        if (expect_change) exp_q.push_back(exp_sel);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
        check("selector_after_frame", int'(selector), int'(exp_sel));
        check("expected_changes_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        btn_next    = 1'b0;
        btn_prev    = 1'b0;
        auto_en     = 1'b0;
        count       = 8'd52;
        repeat (3) tick();
        check("reset_selector", int'(selector), 0);
        check("reset_changed", int'(changed), 0);
        rst_n = 1'b1;
        tick();

        // Held press changes nothing until frame_start.
        btn_next = 1'b1;
        repeat (10) tick();
        btn_next = 1'b0;
        repeat (10) tick();
        check("no_change_before_frame", int'(selector), 0);
        frame(1'b1, 8'd1);

        // Two-cycle glitch is rejected.
        btn_next = 1'b1;
        repeat (2) tick();
        btn_next = 1'b0;
        repeat (10) tick();
        frame(1'b0, 8'd1);

        // Wrap both directions around 0 / 51.
        press_btn(1'b0); frame(1'b1, 8'd0);
        press_btn(1'b0); frame(1'b1, 8'd51);
        press_btn(1'b1); frame(1'b1, 8'd0);
        press_btn(1'b0); frame(1'b1, 8'd51);
        press_btn(1'b1); frame(1'b1, 8'd0);

        // Auto-advance every third frame; a manual step restarts the count.
        auto_en = 1'b1;
        frame(1'b0, 8'd0);
        frame(1'b0, 8'd0);
        frame(1'b1, 8'd1);
        frame(1'b0, 8'd1);
        press_btn(1'b1);
        frame(1'b1, 8'd2);
        frame(1'b0, 8'd2);
        frame(1'b0, 8'd2);
        frame(1'b1, 8'd3);
        auto_en = 1'b0;
        frame(1'b0, 8'd3);

        // Walk back to 40.
        m_sel = 8'd3;
        for (int i = 0; i < 15; i++) begin
            m_sel = (m_sel == 8'd0) ? 8'd51 : m_sel - 8'd1;
            press_btn(1'b0);
            frame(1'b1, m_sel);
        end
        check("walked_to_40", int'(selector), 40);

        // Count shrinks below selector.
        count = 8'd20;
        frame(1'b1, 8'd0);

        // Empty count ignores presses, and they do not linger.
        count = 8'd0;
        press_btn(1'b1);
        frame(1'b0, 8'd0);
        count = 8'd52;
        frame(1'b0, 8'd0);

        // Single flag: next wraps onto itself but still pulses changed.
        count = 8'd1;
        press_btn(1'b1);
        frame(1'b1, 8'd0);
        count = 8'd52;

        // Next and prev together cancel.
        press_btn(1'b1);
        press_btn(1'b0);
        frame(1'b0, 8'd0);
        frame(1'b0, 8'd0);

        // Repeat presses within one frame give a single step.
        press_btn(1'b1);
        press_btn(1'b1);
        frame(1'b1, 8'd1);

        // Reset while a held button is debouncing.
        btn_next = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("midreset_selector", int'(selector), 0);
        check("midreset_changed", int'(changed), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        frame(1'b0, 8'd0);
        repeat (5) tick();
        frame(1'b1, 8'd1);
        btn_next = 1'b0;
        repeat (10) tick();
        frame(1'b0, 8'd1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
